alu_dispatch: RTL

ALU_DISPATCH -- requirements
Module: alu_dispatch

---
 rtl/alu_dispatch.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_dispatch.sv
// alu_dispatch: decodes RV32I instructions into ALU requests behind a
// 2-entry skid buffer with a valid/ready handshake on both sides.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       upstream handshake
//   instr, pc               instruction word and address
//   rs1_data, rs2_data      register-file read values
//   flush                   synchronous discard of held entries
//   out_valid/out_ready     downstream handshake
//   alu_a, alu_b, alu_ctrl  ALU operands and op code
//   out_rd, out_illegal     destination register, illegal flag
module alu_dispatch #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    output logic [4:0]       out_rd,
    output logic             out_illegal
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       ctrl;
        logic [4:0]       rd;
        logic             ill;
    } pay_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SUB  = 4'b1000;
    localparam logic [3:0] C_SLT  = 4'b0010;
    localparam logic [3:0] C_SLTU = 4'b0011;

    logic [6:0]       w_op;
    logic [2:0]       w_f3;
    logic [6:0]       w_f7;
    logic [WIDTH-1:0] w_imm_i;
    logic [WIDTH-1:0] w_imm_s;
    logic [WIDTH-1:0] w_imm_u;
    logic [WIDTH-1:0] w_shamt;
    pay_t             w_dec;
    logic             w_ill;

    pay_t r_out;
    pay_t r_skid;
    logic r_out_v;
    logic r_skid_v;
    logic r_live;
    logic w_acc;
    logic w_out_fire;

    assign w_op    = instr[6:0];
    assign w_f3    = instr[14:12];
    assign w_f7    = instr[31:25];
    assign w_imm_i = WIDTH'($signed(instr[31:20]));
    assign w_imm_s = WIDTH'($signed({instr[31:25], instr[11:7]}));
    assign w_imm_u = WIDTH'($signed({instr[31:12], 12'b0}));
    assign w_shamt = WIDTH'(instr[24:20]);

    always_comb begin
        w_dec      = '0;
        w_ill      = 1'b0;
        w_dec.rd   = instr[11:7];
        w_dec.a    = rs1_data;
        case (w_op)
            OP_R: begin
                w_dec.b    = rs2_data;
                w_dec.ctrl = {w_f7[5], w_f3};
                if (w_f7 == 7'h20) begin
                    w_ill = (w_f3 != 3'b000) && (w_f3 != 3'b101);
                end else begin
                    w_ill = (w_f7 != 7'h00);
                end
            end
            OP_IMM: begin
                // Shifts take an unsigned shamt; funct7 selects SRA.
                if (w_f3 == 3'b001) begin
                    w_dec.b    = w_shamt;
                    w_dec.ctrl = {1'b0, w_f3};
                    w_ill      = (w_f7 != 7'h00);
                end else if (w_f3 == 3'b101) begin
                    w_dec.b    = w_shamt;
                    w_dec.ctrl = {w_f7[5], w_f3};
                    w_ill      = (w_f7 != 7'h00) && (w_f7 != 7'h20);
                end else begin
                    w_dec.b    = w_imm_i;
                    w_dec.ctrl = {1'b0, w_f3};
                end
            end
            OP_LOAD: begin
                w_dec.b    = w_imm_i;
                w_dec.ctrl = C_ADD;
            end
            OP_STORE: begin
                w_dec.b    = w_imm_s;
                w_dec.ctrl = C_ADD;
                w_dec.rd   = 5'd0;
            end
            OP_BRANCH: begin
                w_dec.b  = rs2_data;
                w_dec.rd = 5'd0;
                case (w_f3[2:1])
                    2'b00:   w_dec.ctrl = C_SUB;
                    2'b10:   w_dec.ctrl = C_SLT;
                    2'b11:   w_dec.ctrl = C_SLTU;
                    default: w_ill      = 1'b1;
                endcase
            end
            OP_LUI: begin
                w_dec.a    = '0;
                w_dec.b    = w_imm_u;
                w_dec.ctrl = C_ADD;
            end
            OP_AUIPC: begin
                w_dec.a    = pc;
                w_dec.b    = w_imm_u;
                w_dec.ctrl = C_ADD;
            end
            OP_JAL: begin
                w_dec.a    = pc;
                w_dec.b    = WIDTH'(4);
                w_dec.ctrl = C_ADD;
            end
            OP_JALR: begin
                w_dec.a    = pc;
                w_dec.b    = WIDTH'(4);
                w_dec.ctrl = C_ADD;
                w_ill      = (w_f3 != 3'b000);
            end
            default: w_ill = 1'b1;
        endcase
        // Illegal ops still flow through, but with neutral operands.
        if (w_ill) begin
            w_dec.a    = '0;
            w_dec.b    = '0;
            w_dec.ctrl = C_ADD;
            w_dec.rd   = instr[11:7];
        end
        w_dec.ill = w_ill;
    end

    // r_live holds in_ready low until the first edge after reset.
    assign in_ready   = r_live & ~r_skid_v;
    assign w_acc      = in_valid & in_ready & ~flush;
    assign w_out_fire = r_out_v & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out    <= '0;
            r_skid   <= '0;
            r_out_v  <= 1'b0;
            r_skid_v <= 1'b0;
            r_live   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (flush) begin
                r_out_v  <= 1'b0;
                r_skid_v <= 1'b0;
            end else if (!r_out_v || w_out_fire) begin
                // Skid is only full while in_ready is low, so it
                // never competes with a new accept here.
                if (r_skid_v) begin
                    r_out    <= r_skid;
                    r_out_v  <= 1'b1;
                    r_skid_v <= 1'b0;
                end else if (w_acc) begin
                    r_out   <= w_dec;
                    r_out_v <= 1'b1;
                end else begin
                    r_out_v <= 1'b0;
                end
            end else if (w_acc) begin
                r_skid   <= w_dec;
                r_skid_v <= 1'b1;
            end
        end
    end

    assign out_valid   = r_out_v;
    assign alu_a       = r_out.a;
    assign alu_b       = r_out.b;
    assign alu_ctrl    = r_out.ctrl;
    assign out_rd      = r_out.rd;
    assign out_illegal = r_out.ill;

endmodule
